// File: rtl/regfile_debug_ctrl.sv
// Debug controller between a core and its register file: halts the core at
// instruction boundaries, single-steps it, and serves debug register reads/writes.
//
// state  | meaning
// RUN    | core runs freely, signals pass through
// DRAIN  | halt requested, waiting for the current instruction to finish
// HALTED | core stalled, debug port ready
// ACCESS | one-cycle debug register access
// STEP   | core runs until one instruction completes, then halts again
module regfile_debug_ctrl #(
    parameter int DataWidth   = 16,
    parameter int NumRegs     = 8,
    parameter int IndexWidth  = $clog2(NumRegs),
    parameter bit HaltOnReset = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  core_we,
    input  logic                  core_count_en,
    input  logic [IndexWidth-1:0] core_waddr,
    input  logic [IndexWidth-1:0] core_raddr1,
    input  logic [IndexWidth-1:0] core_raddr2,
    input  logic [DataWidth-1:0]  core_wdata,
    input  logic                  core_instr_done,
    output logic                  core_stall,
    output logic                  rf_we,
    output logic                  rf_count_en,
    output logic [IndexWidth-1:0] rf_waddr,
    output logic [IndexWidth-1:0] rf_raddr1,
    output logic [IndexWidth-1:0] rf_raddr2,
    output logic [DataWidth-1:0]  rf_wdata,
    input  logic [DataWidth-1:0]  rf_rdata1,
    input  logic                  dbg_halt_req,
    input  logic                  dbg_resume,
    input  logic                  dbg_step,
    input  logic                  dbg_valid,
    output logic                  dbg_ready,
    input  logic                  dbg_write,
    input  logic [IndexWidth-1:0] dbg_addr,
    input  logic [DataWidth-1:0]  dbg_wdata,
    output logic [DataWidth-1:0]  dbg_rdata,
    output logic                  dbg_rvalid,
    output logic                  halted
);

    typedef enum logic [2:0] {
        S_RUN,
        S_DRAIN,
        S_HALTED,
        S_ACCESS,
        S_STEP
    } state_t;

    state_t                state, state_nxt;
    logic                  cap_write;
    logic [IndexWidth-1:0] cap_addr;
    logic [DataWidth-1:0]  cap_wdata;
    logic                  accept;

    assign accept = (state == S_HALTED) && dbg_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if (HaltOnReset) state <= S_HALTED;
            else             state <= S_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_write  <= 1'b0;
            cap_addr   <= '0;
            cap_wdata  <= '0;
            dbg_rdata  <= '0;
            dbg_rvalid <= 1'b0;
        end else begin
            if (accept) begin
                cap_write <= dbg_write;
                cap_addr  <= dbg_addr;
                cap_wdata <= dbg_wdata;
            end
            // ACCESS always lasts one cycle, so this edge is the one leaving it
            dbg_rvalid <= (state == S_ACCESS) && !cap_write;
            if ((state == S_ACCESS) && !cap_write) dbg_rdata <= rf_rdata1;
        end
    end

    always_comb begin
        state_nxt   = state;
        core_stall  = 1'b0;
        halted      = 1'b0;
        dbg_ready   = 1'b0;
        rf_we       = core_we;
        rf_count_en = core_count_en;
        rf_waddr    = core_waddr;
        rf_wdata    = core_wdata;
        rf_raddr1   = core_raddr1;
        rf_raddr2   = core_raddr2;
        case (state)
            S_RUN: begin
                if (dbg_halt_req) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (core_instr_done) state_nxt = S_HALTED;
            end
            S_STEP: begin
                if (core_instr_done) state_nxt = S_HALTED;
            end
            S_HALTED: begin
                core_stall  = 1'b1;
                halted      = 1'b1;
                dbg_ready   = 1'b1;
                rf_we       = 1'b0;
                rf_count_en = 1'b0;
                if (dbg_valid)       state_nxt = S_ACCESS;
                else if (dbg_step)   state_nxt = S_STEP;
                else if (dbg_resume) state_nxt = S_RUN;
            end
            S_ACCESS: begin
                core_stall  = 1'b1;
                halted      = 1'b1;
                rf_we       = cap_write;
                rf_count_en = 1'b0;
                rf_waddr    = cap_addr;
                rf_wdata    = cap_wdata;
                rf_raddr1   = cap_addr;
                state_nxt   = S_HALTED;
            end
            default: begin
                state_nxt = S_HALTED;
            end
        endcase
    end

endmodule

// File: doc/regfile_debug_ctrl.md
REGFILE_DEBUG_CTRL -- requirements
Module: regfile_debug_ctrl

Interface
REQ-001 SHALL have parameter DataWidth, default 16, register data width.
REQ-002 SHALL have parameter NumRegs, default 8, register count; index NumRegs-1 is the program counter.
REQ-003 SHALL have parameter IndexWidth, default $clog2(NumRegs), register index width.
REQ-004 SHALL have parameter HaltOnReset, default 0, which selects HALTED (1) or RUN (0) as the reset state.
REQ-005 SHALL have these ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- core_we, core_count_en  in  1 each  core write enable and PC increment request.
- core_waddr, core_raddr1, core_raddr2  in  IndexWidth each  core register addresses.
- core_wdata  in  DataWidth  core write data.
- core_instr_done  in  1  single-cycle pulse on the last cycle of a core instruction.
- core_stall  out  1  holds the core.
- rf_we, rf_count_en  out  1 each  register-file write enable and PC increment.
- rf_waddr, rf_raddr1, rf_raddr2  out  IndexWidth each  register-file addresses.
- rf_wdata  out  DataWidth  register-file write data.
- rf_rdata1  in  DataWidth  register-file read port 1 data.
- dbg_halt_req, dbg_resume, dbg_step  in  1 each  debug commands, sampled as levels.
- dbg_valid  in  1  debug access request.
- dbg_ready  out  1  debug access accepted.
- dbg_write  in  1  1=write, 0=read.
- dbg_addr  in  IndexWidth  register index of the debug access.
- dbg_wdata  in  DataWidth  debug write data.
- dbg_rdata  out  DataWidth  registered debug read data.
- dbg_rvalid  out  1  single-cycle read-data strobe.
- halted  out  1  core is stopped.

Function
REQ-006 SHALL implement the states RUN, DRAIN, HALTED, ACCESS and STEP.
REQ-007 In RUN, DRAIN and STEP, the block SHALL pass all core_* signals through to the matching rf_* outputs and drive core_stall=0.
REQ-008 In HALTED and ACCESS, the block SHALL drive core_stall=1 and rf_count_en=0, and SHALL block core_we from rf_we.
REQ-009 rf_raddr2 SHALL equal core_raddr2 in every state.
REQ-010 Transition RUN->DRAIN SHALL occur on dbg_halt_req=1.
REQ-011 Transition DRAIN->HALTED SHALL occur on core_instr_done=1; the core signals of that cycle still pass through.
REQ-012 RUN with dbg_halt_req=1 and core_instr_done=1 in the same cycle SHALL go to DRAIN, not directly to HALTED.
REQ-013 dbg_ready SHALL be 1 only in HALTED; a debug access is accepted on dbg_valid=1 with dbg_ready=1.
REQ-014 On acceptance, the block SHALL register dbg_write, dbg_addr and dbg_wdata and go to ACCESS.
REQ-015 ACCESS SHALL last exactly one cycle and then return to HALTED.
REQ-016 An ACCESS write SHALL drive rf_we=1, rf_waddr=captured addr and rf_wdata=captured data.
REQ-017 A debug write to index 0 SHALL be issued unchanged; the register file discards it.
REQ-018 An ACCESS read SHALL drive rf_raddr1=captured addr with rf_we=0, and SHALL load dbg_rdata from rf_rdata1 at the edge that leaves ACCESS.
REQ-019 dbg_rvalid SHALL be 1 for exactly the cycle after a read ACCESS and 0 otherwise; it SHALL stay 0 after writes.
REQ-020 dbg_rdata SHALL hold its value until the next read completes.
REQ-021 HALTED priority SHALL be: dbg_valid (->ACCESS), then dbg_step (->STEP), then dbg_resume (->RUN); lower-priority commands in that cycle are dropped.
REQ-022 Transition STEP->HALTED SHALL occur on core_instr_done=1; dbg_halt_req has no effect during STEP.
REQ-023 dbg_resume and dbg_step SHALL be ignored outside HALTED, and dbg_halt_req SHALL be ignored outside RUN.
REQ-024 halted SHALL be 1 in HALTED and ACCESS and 0 in all other states.
REQ-025 In states other than ACCESS, rf_raddr1 SHALL equal core_raddr1.
REQ-026 Core instructions SHALL never be split: a halt only takes effect at a core_instr_done boundary.

Reset
REQ-027 While rst=1, the block SHALL asynchronously enter RUN (HaltOnReset=0) or HALTED (HaltOnReset=1).
REQ-028 Reset SHALL clear dbg_rdata and dbg_rvalid to 0 and clear the captured request.
REQ-029 Reset during ACCESS SHALL abort it with no rf_we pulse after rst rises and no dbg_rvalid.
REQ-030 After reset release, halted, core_stall and dbg_ready SHALL reflect the reset state in the first cycle.

Verification
REQ-031 Halt: in RUN, dbg_halt_req=1, core_instr_done pulsed 3 cycles later -> halted=1 the next cycle; core_count_en=1 is blocked (rf_count_en=0).
REQ-032 Write/read: when HALTED, write reg 3=0xBEEF, then read reg 3 -> rf_we pulse in ACCESS; dbg_rdata=0xBEEF with dbg_rvalid=1 for one cycle, two cycles after read acceptance.
REQ-033 Step: when HALTED, dbg_step=1, core_instr_done after 4 cycles -> core_stall=0 for those cycles, then back to HALTED, with PC advanced by exactly the core's increments.
REQ-034 Priority: when HALTED, dbg_valid, dbg_step and dbg_resume all 1 -> ACCESS only; next state HALTED.
REQ-035 Reset: rst asserted in ACCESS with a write to reg 5 -> no rf_we after rst rises, dbg_rvalid=0, state RUN (HaltOnReset=0) or HALTED (HaltOnReset=1).
REQ-036 Boundary: dbg_halt_req and core_instr_done together in RUN -> DRAIN, then HALTED only on the next core_instr_done.
